// File: rtl/br_predict_param_pkg.sv
// Shared predictor types: datapath word, the BTB entry record for the default geometry, and the weak-taken helper.
// Latency: n/a (types only); backpressure: n/a.
package br_predict_param_pkg;

    typedef logic [31:0] word_t;

    localparam int BTB_TAG_W = 8;
    localparam int BTB_CTR_W = 2;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_CTR_W-1:0] ctr;
        word_t                target;
    } btb_entry_t;

    // Weakly-taken is the smallest counter value whose MSB predicts taken.
    function automatic int unsigned weakTaken(input int unsigned ctrW);
        return 32'd1 << (ctrW - 1);
    endfunction

    localparam logic [BTB_CTR_W-1:0] CTR_WEAK_TAKEN = BTB_CTR_W'(weakTaken(BTB_CTR_W));

endpackage

// File: rtl/br_predict_param_sat.sv
// Saturating up/down counter next-value: stops at all-ones going up and at zero going down.
// Latency: combinational; backpressure: none.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         up,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (up) begin
            if (cur != '1) nxt = cur + W'(1);
        end else begin
            if (cur != '0) nxt = cur - W'(1);
        end
    end

endmodule

// File: rtl/br_predict_param.sv
// Tagged direct-mapped BTB with saturating direction counters; BTB_GSHARE_EN folds global history into the index.
// Latency: lookup combinational, update registered one edge; backpressure: none, every upd_valid edge is accepted.
module br_predict_param
    import br_predict_param_pkg::*;
#(
    parameter  int ENTRIES  = 16,
    parameter  int TAG_W    = 8,
    parameter  int CTR_W    = 2,
    parameter  int CTR_INIT = 1,
    parameter  int HIST_W   = 4,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      rd_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [IDX_W-1:0] pred_index,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             clr
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [CTR_W-1:0] ctr;
        word_t            target;
    } entryT;

    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(weakTaken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_RST  = CTR_W'(CTR_INIT);

    entryT btb [ENTRIES];

    logic [HIST_W-1:0] ghr;
    logic [IDX_W-1:0]  rdIdx;
    entryT             rdEntry;
    entryT             updEntry;
    logic [TAG_W-1:0]  updTag;
    logic              updHit;
    logic [CTR_W-1:0]  ctrNext;
    logic              unusedUpdPc;

    // With history disabled ghr is tied to zero, so the XOR collapses to the plain PC slice.
    assign rdIdx   = rd_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign rdEntry = btb[rdIdx];

    assign pred_hit    = rdEntry.valid && (rdEntry.tag == rd_pc[IDX_W+2 +: TAG_W]);
    assign pred_taken  = pred_hit && rdEntry.ctr[CTR_W-1];
    assign pred_target = pred_taken ? rdEntry.target : rd_pc + 32'd4;
    assign pred_index  = rdIdx;

    assign updEntry    = btb[upd_index];
    assign updTag      = upd_pc[IDX_W+2 +: TAG_W];
    assign updHit      = updEntry.valid && (updEntry.tag == updTag);
    assign unusedUpdPc = ^upd_pc;

    sat_counter #(
        .W (CTR_W)
    ) u_sat (
        .cur (updEntry.ctr),
        .up  (upd_taken),
        .nxt (ctrNext)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_RST, target: '0};
            end
        end else if (clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
                btb[i].ctr   <= CTR_RST;
            end
        end else if (upd_valid) begin
            if (updHit) begin
                btb[upd_index].ctr <= ctrNext;
                if (upd_taken) btb[upd_index].target <= upd_target;
            end else if (upd_taken) begin
                // Taken miss replaces whatever occupied the slot.
                btb[upd_index] <= '{valid: 1'b1, tag: updTag, ctr: CTR_WEAK, target: upd_target};
            end
        end
    end

`ifdef BTB_GSHARE_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ghr <= '0;
        end else if (clr) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= HIST_W'({ghr, upd_taken});
        end
    end
`else
    assign ghr = '0;
`endif

endmodule

// File: tb/tb_br_predict_param.sv
// Directed bench for br_predict_param at default parameters; BTB_GSHARE_EN selects the history scenario.
module tb_br_predict_param;

    logic        CLK;
    logic        nRST;
    logic [31:0] rd_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_index;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [3:0]  upd_index;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        clr;

    int nChecks = 0;
    int nErrors = 0;

    br_predict_param dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .rd_pc       (rd_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pred_index  (pred_index),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_index   (upd_index),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .clr         (clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One update pulse spanning a single rising edge; returns on the following falling edge.
    task automatic upd(input logic [31:0] pc, input logic [3:0] idx, input logic tk, input logic [31:0] tgt);
        @(negedge CLK);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_index  = idx;
        upd_taken  = tk;
        upd_target = tgt;
        @(negedge CLK);
        upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic h, input logic t,
                        input logic [31:0] tgt);
        rd_pc = pc;
        #1;
        checkVal({tag, "_hit"}, 32'(pred_hit), 32'(h));
        checkVal({tag, "_taken"}, 32'(pred_taken), 32'(t));
        checkVal({tag, "_target"}, pred_target, tgt);
    endtask

    initial begin
        nRST       = 1'b0;
        clr        = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_index  = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        rd_pc      = 32'h40;
        #12;
        look("reset", 32'h40, 1'b0, 1'b0, 32'h44);
        checkVal("reset_index", 32'(pred_index), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

`ifdef BTB_GSHARE_EN
        upd(32'h40, 4'd0, 1'b1, 32'h100);
        upd(32'h44, 4'd1, 1'b1, 32'h200);
        upd(32'h48, 4'd2, 1'b0, 32'h300);
        rd_pc = 32'h40;
        #1 checkVal("gshare_idx_40", 32'(pred_index), 32'd6);
        rd_pc = 32'h5C;
        #1 checkVal("gshare_idx_5c", 32'(pred_index), 32'd1);
        @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK);
        clr = 1'b0;
        rd_pc = 32'h40;
        #1 checkVal("gshare_clr_idx", 32'(pred_index), 32'd0);
`else
        rd_pc = 32'h5C;
        #1 checkVal("index_5c", 32'(pred_index), 32'd7);

        upd(32'h40, 4'd0, 1'b1, 32'h100);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

        upd(32'h40, 4'd0, 1'b0, 32'h0);
        look("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 4'd0, 1'b0, 32'h0);
        upd(32'h40, 4'd0, 1'b0, 32'h0);
        upd(32'h40, 4'd1 - 4'd1, 1'b1, 32'h180);
        look("t_from0", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 4'd0, 1'b1, 32'h200);
        look("t_to2", 32'h40, 1'b1, 1'b1, 32'h200);
        upd(32'h40, 4'd0, 1'b1, 32'h200);
        upd(32'h40, 4'd0, 1'b1, 32'h200);
        upd(32'h40, 4'd0, 1'b0, 32'h999);
        look("sat_hi", 32'h40, 1'b1, 1'b1, 32'h200);

        look("alias_miss", 32'h440, 1'b0, 1'b0, 32'h444);
        upd(32'h440, 4'd0, 1'b1, 32'h300);
        look("alias_new", 32'h440, 1'b1, 1'b1, 32'h300);
        look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);

        upd(32'h84, 4'd1, 1'b0, 32'h500);
        look("miss_nt", 32'h84, 1'b0, 1'b0, 32'h88);

        @(negedge CLK);
        rd_pc      = 32'h40;
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_index  = 4'd0;
        upd_taken  = 1'b1;
        upd_target = 32'h600;
        #1 checkVal("same_cycle_old", 32'(pred_hit), 32'd0);
        @(negedge CLK);
        upd_valid = 1'b0;
        look("same_cycle_new", 32'h40, 1'b1, 1'b1, 32'h600);

        @(negedge CLK);
        clr        = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h84;
        upd_index  = 4'd1;
        upd_taken  = 1'b1;
        upd_target = 32'h700;
        @(negedge CLK);
        clr       = 1'b0;
        upd_valid = 1'b0;
        look("clr_40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("clr_84", 32'h84, 1'b0, 1'b0, 32'h88);

        upd(32'h40, 4'd0, 1'b1, 32'h100);
        look("pre_arst", 32'h40, 1'b1, 1'b1, 32'h100);
        nRST = 1'b0;
        #1;
        checkVal("arst_hit", 32'(pred_hit), 32'd0);
        checkVal("arst_target", pred_target, 32'h44);
        @(negedge CLK);
        nRST = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
